// File: rtl/mem_bus_if.sv
// rtl/mem_bus_if.sv - data-side Wishbone-classic bus master for the memory pipeline stage
module mem_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stall_req_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i
);

    localparam int SEL_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;

    // Byte offset is dropped on the bus; lanes are chosen by sel.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rd_buf_d    = rd_buf_q;
        stall_req_o = 1'b0;
        cpu_data_o  = '0;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    stall_req_o = 1'b1;
                    cyc_d       = 1'b1;
                    we_d        = cpu_we_i;
                    adr_d       = {cpu_addr_i[ADDR_W-1:2], 2'b00};
                    sel_d       = cpu_sel_i;
                    dat_d       = cpu_data_i;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (wb_ack_i) begin
                    // Ack wins over a same-cycle flush: the access already happened.
                    cpu_data_o = wb_dat_i;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    sel_d   = '0;
                    dat_d   = '0;
                    state_d = stall_i ? HOLD : IDLE;
                end else begin
                    stall_req_o = 1'b1;
                    if (flush_i) begin
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        adr_d   = '0;
                        sel_d   = '0;
                        dat_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                // Keep presenting captured data so the frozen stage never reissues.
                cpu_data_o = rd_buf_q;
                if (!stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            rd_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_sel_o = sel_q;
    assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_mem_bus_if.sv
// tb/tb_mem_bus_if.sv - self-checking bench for mem_bus_if with a transaction-level reference model
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, cpu_ce_i, cpu_we_i;
    logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
    logic [3:0]  cpu_sel_i;
    logic        stall_req_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stall_req_o(stall_req_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_sel_o   (wb_sel_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    // Reference model: an outstanding transaction record plus a "held result" record.
    bit          m_pending;
    bit          m_holding;
    bit          m_we;
    logic [31:0] m_adr, m_dat, m_buf;
    logic [3:0]  m_sel;
    int          stb_rises;
    logic        prev_stb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive at the falling edge, check 1ns later, then advance the model.
    task automatic step(input logic r, input logic ce, input logic we, input logic [31:0] addr,
                        input logic [3:0] sel, input logic [31:0] data, input logic st,
                        input logic fl, input logic ak, input logic [31:0] di);
        logic        exp_stall;
        logic [31:0] exp_data;
        @(negedge clk);
        rst = r; cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel;
        cpu_data_i = data; stall_i = st; flush_i = fl; wb_ack_i = ak; wb_dat_i = di;
        #1;
        exp_stall = (!m_pending && !m_holding && ce && !fl) || (m_pending && !ak);
        exp_data  = (m_pending && ak) ? di : (m_holding ? m_buf : 32'h0);
        check("wb_cyc", {31'b0, wb_cyc_o}, {31'b0, m_pending});
        check("wb_stb", {31'b0, wb_stb_o}, {31'b0, m_pending});
        check("wb_we", {31'b0, wb_we_o}, {31'b0, m_pending && m_we});
        check("wb_adr", wb_adr_o, m_pending ? m_adr : 32'h0);
        check("wb_sel", {28'b0, wb_sel_o}, m_pending ? {28'b0, m_sel} : 32'h0);
        check("wb_dat", wb_dat_o, m_pending ? m_dat : 32'h0);
        check("stall_req", {31'b0, stall_req_o}, {31'b0, exp_stall});
        check("cpu_data", cpu_data_o, exp_data);
        if (wb_stb_o && !prev_stb) stb_rises++;
        prev_stb = wb_stb_o;

        if (r) begin
            m_pending = 0; m_holding = 0; m_buf = 0;
        end else if (m_pending) begin
            if (ak) begin
                if (!m_we) m_buf = di;
                m_pending = 0;
                m_holding = st;
            end else if (fl) begin
                m_pending = 0;
            end
        end else if (m_holding) begin
            if (!st || fl) m_holding = 0;
        end else if (ce && !fl) begin
            m_pending = 1;
            m_we  = we;
            m_adr = {addr[31:2], 2'b00};
            m_sel = sel;
            m_dat = data;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0;
        cpu_addr_i = 0; cpu_sel_i = 0; cpu_data_i = 0; wb_dat_i = 0; wb_ack_i = 0;
        m_pending = 0; m_holding = 0; m_we = 0; m_adr = 0; m_dat = 0; m_buf = 0; m_sel = 0;
        stb_rises = 0; prev_stb = 0;
        repeat (2) @(posedge clk);

        // Reset state
        idle(1);

        // Read, zero wait
        step(0, 1, 0, 32'h0000_1006, 4'b0010, 0, 0, 0, 0, 0);
        check("rd0_stall_c0", {31'b0, stall_req_o}, 32'h1);
        step(0, 1, 0, 32'h0000_1006, 4'b0010, 0, 0, 0, 1, 32'hA1B2_C3D4);
        check("rd0_adr", wb_adr_o, 32'h0000_1004);
        check("rd0_sel", {28'b0, wb_sel_o}, 32'h2);
        check("rd0_data", cpu_data_o, 32'hA1B2_C3D4);
        check("rd0_stall_c1", {31'b0, stall_req_o}, 32'h0);
        idle(1);

        // Write, three wait states
        step(0, 1, 1, 32'h0000_2000, 4'hF, 32'h5555_5555, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h0000_2000, 4'hF, 32'h5555_5555, 0, 0, 0, 0);
        step(0, 1, 1, 32'h0000_2000, 4'hF, 32'h5555_5555, 0, 0, 1, 32'hDEAD_BEEF);
        idle(1);
        check("wr_cleared", {31'b0, wb_cyc_o}, 32'h0);

        // Read completing under an external stall
        stb_rises = 0;
        step(0, 1, 0, 32'h0000_3008, 4'hF, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0000_3008, 4'hF, 0, 1, 0, 1, 32'h1234_5678);
        step(0, 1, 0, 32'h0000_3008, 4'hF, 0, 1, 0, 1, 32'h9999_9999);
        check("hold_data", cpu_data_o, 32'h1234_5678);
        check("hold_stall", {31'b0, stall_req_o}, 32'h0);
        step(0, 1, 0, 32'h0000_3008, 4'hF, 0, 1, 0, 0, 0);
        step(0, 1, 0, 32'h0000_3008, 4'hF, 0, 0, 0, 0, 0);
        idle(2);
        check("hold_one_pulse", stb_rises, 1);

        // Flush in BUSY without ack, then flush coinciding with ack
        step(0, 1, 0, 32'h0000_4000, 4'hF, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0000_4000, 4'hF, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("flush_cyc", {31'b0, wb_cyc_o}, 32'h0);
        step(0, 1, 0, 32'h0000_4004, 4'hF, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0000_4004, 4'hF, 0, 0, 1, 1, 32'hCAFE_F00D);
        check("flush_ack_data", cpu_data_o, 32'hCAFE_F00D);
        idle(1);

        // Reset mid-BUSY; subsequent ack ignored
        step(0, 1, 0, 32'h0000_5000, 4'hF, 0, 0, 0, 0, 0);
        step(1, 1, 0, 32'h0000_5000, 4'hF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777);
        check("rst_data", cpu_data_o, 32'h0);
        idle(1);

        // Back-to-back reads
        step(0, 1, 0, 32'h0000_6000, 4'hF, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h0000_6000, 4'hF, 0, 0, 0, 1, 32'h1111_1111);
        step(0, 1, 0, 32'h0000_6104, 4'hF, 0, 0, 0, 0, 0);
        check("b2b_gap", {31'b0, wb_cyc_o}, 32'h0);
        step(0, 1, 0, 32'h0000_6104, 4'hF, 0, 0, 0, 1, 32'h2222_2222);
        check("b2b_adr2", wb_adr_o, 32'h0000_6104);
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), $urandom_range(0, 1) == 1,
                 $urandom, 4'($urandom_range(1, 15)), $urandom,
                 ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
# mem_bus_if

Data-side bus master between the memory-access pipeline stage and the external Wishbone-classic data bus. It takes the stage's combinational request (ce/we/addr/sel/data), runs a multi-cycle bus transaction, and raises a stall request to the pipeline controller until the acknowledge arrives. It returns read data to the stage's memory-data input. It also holds captured read data while the pipeline is frozen by another cause, so that no transaction is reissued.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; select width is DATA_W/8
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  memory stage held by an external cause (pipeline stall bit for this stage)
- flush_i  in  1  pipeline flush; kills the pending request
- cpu_ce_i  in  1  request valid from memory stage
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_W  byte address
- cpu_sel_i  in  DATA_W/8  byte-lane select (bit 3 = bits 31:24)
- cpu_data_i  in  DATA_W  write data (already lane-replicated)
- cpu_data_o  out  DATA_W  read data to memory stage
- stall_req_o  out  1  hold pipeline (combinational)
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone cycle/strobe/write
- wb_adr_o  out  ADDR_W  word-aligned address, {cpu_addr_i[ADDR_W-1:2], 2'b00}
- wb_sel_o  out  DATA_W/8  byte select
- wb_dat_o  out  DATA_W  write data
- wb_dat_i  in  DATA_W  read data
- wb_ack_i  in  1  slave acknowledge

## Operation
- All wb_* outputs are registered. The state, read buffer rd_buf, and wb_* outputs reset to 0 / IDLE.
- States: IDLE, BUSY, HOLD.
- IDLE:
  - cpu_ce_i=1 and flush_i=0: register wb_cyc/stb=1, wb_we=cpu_we_i, adr, sel, dat from cpu_*. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, wb_ack_i=1:
  - Clear wb_cyc/stb/we/sel/adr/dat to 0.
  - Read (wb_we_o=0): rd_buf <= wb_dat_i. Write: rd_buf unchanged.
  - stall_i=1: go to HOLD. Otherwise go to IDLE.
- BUSY, wb_ack_i=0, flush_i=1: abort. Clear wb_cyc/stb and all bus outputs, go to IDLE. An ack in the same cycle takes priority over the flush; the transaction completes normally.
- BUSY, no ack, no flush: hold all bus outputs stable.
- HOLD:
  - stall_i=0 or flush_i=1: go to IDLE.
  - Never issues a bus cycle.
- stall_req_o (combinational):
  - 1 in IDLE when cpu_ce_i=1 and flush_i=0.
  - 1 in BUSY when wb_ack_i=0.
  - 0 otherwise, including HOLD.
- cpu_data_o (combinational):
  - wb_dat_i in BUSY with wb_ack_i=1.
  - rd_buf in HOLD.
  - 0 otherwise.
- The block performs no lane extraction or sign extension; the memory stage does that.
- A write never updates cpu_data_o with meaningful data; it is don't-care but must follow the rules above.

## Timing
- The request is seen in cycle 0 (IDLE) and stall_req_o=1 in cycle 0.
- wb_cyc/stb are first high in cycle 1.
- With zero-wait ack (ack in cycle 1): stall_req_o=0 and cpu_data_o valid in cycle 1. The pipeline advances at the end of cycle 1, and the block is in IDLE in cycle 2.
- A k-wait-state slave extends BUSY by k cycles. Minimum occupancy is 2 cycles per access.
- Back-to-back requests: the next request is accepted in the first IDLE cycle after ack or HOLD. wb_cyc drops for at least 1 cycle between transactions.
- rst asserted mid-transaction: at the next edge, wb_cyc/stb drop to 0, the state returns to IDLE, and rd_buf is cleared. No ack is expected after reset.
- An ack outside BUSY is ignored.

## Test plan
- Read, 0 wait: ce=1, we=0, addr=0x0000_1006, sel=0010, ack in cycle 1 with dat=0xA1B2C3D4 -> wb_adr=0x0000_1004, sel=0010; stall_req 1,0; cpu_data_o=0xA1B2C3D4 in cycle 1; IDLE in cycle 2.
- Write, 3 wait states: ce=1, we=1, data=0x5555_5555, sel=1111 -> wb_we=1 and outputs stable for 4 cycles; stall_req=1 until the ack cycle; bus cleared the cycle after ack.
- Stall after read: ack with dat=0x1234_5678 while stall_i=1 for 3 cycles -> HOLD; cpu_data_o=0x1234_5678, stall_req=0; exactly one wb_stb pulse train; back to IDLE when stall_i falls.
- Flush during BUSY, no ack -> wb_cyc=0 the next cycle, IDLE, stall_req=0. Flush coinciding with ack -> normal completion, with read data returned.
- Reset mid-BUSY with rst=1 for 1 cycle -> all wb_* outputs 0, cpu_data_o=0, stall_req=0 (with ce=0); a later ack is ignored.
- Back-to-back: two reads with ce held, each acked immediately -> cyc pattern 1,0,1; addresses are taken from the respective requests.
